// File: rtl/core_pkg.sv
// Shared core definitions: data width, enable/zero levels and RV32I load funct3 encodings.
// Imported by the writeback stage and its load alignment helper.
package core_pkg;

  localparam int   XLEN   = 32;
  localparam logic ENABLE = 1'b1;
  localparam logic ZERO   = 1'b0;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  // True for the five load encodings RV32I defines; anything else never writes back.
  function automatic logic is_legal_load(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: is_legal_load = ENABLE;
      default:                             is_legal_load = ZERO;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational RV32I load extraction: selects the byte/halfword addressed by addr_lo
// from the raw RAM word, sign/zero extends it and flags misaligned halfword/word loads.
module load_align #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);
  import core_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{addr_lo, 3'b000} +: 8];
  assign half_sel = word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves a latch.
    data       = '0;
    misaligned = ZERO;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        data       = {{(XLEN-16){half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_sel};
        misaligned = addr_lo[0];
      end
      F3_LW: begin
        data       = word;
        misaligned = (addr_lo != 2'b00);
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: aligns loads, drives the register-file write port and the
// execute forwarding bus one cycle after capture, and counts retired instructions.
module mem_wb_stage #(
  parameter int XLEN      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk_i,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [4:0]           rd_i,
  input  logic                 wb_en_i,
  input  logic [XLEN-1:0]      wb_value_i,
  input  logic                 is_load_i,
  input  logic [2:0]           load_funct3_i,
  input  logic [1:0]           addr_lo_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_rd_o,
  output logic [XLEN-1:0]      rf_wdata_o,
  output logic                 fwd_valid_o,
  output logic [4:0]           fwd_rd_o,
  output logic [XLEN-1:0]      fwd_data_o,
  output logic                 misaligned_o,
  output logic [INSTRET_W-1:0] instret_o
);
  import core_pkg::*;

  logic [XLEN-1:0]      load_data;
  logic                 load_misaligned;
  logic                 capture;
  logic                 load_bad;
  logic                 we_next;

  logic                 valid_q;
  logic                 rf_we_q;
  logic [4:0]           rf_rd_q;
  logic [XLEN-1:0]      rf_wdata_q;
  logic                 misaligned_q;
  logic [INSTRET_W-1:0] instret_q;

  load_align #(.XLEN(XLEN)) u_load_align (
    .word       (wb_value_i),
    .addr_lo    (addr_lo_i),
    .funct3     (load_funct3_i),
    .data       (load_data),
    .misaligned (load_misaligned)
  );

  // Flush and stall both collapse to the same bubble, so their relative priority is moot here.
  assign capture  = valid_i & ~stall_i & ~flush_i;
  assign load_bad = is_load_i & (load_misaligned | ~is_legal_load(load_funct3_i));
  assign we_next  = wb_en_i & (rd_i != 5'd0) & ~load_bad;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      valid_q      <= ZERO;
      rf_we_q      <= ZERO;
      rf_rd_q      <= '0;
      rf_wdata_q   <= '0;
      misaligned_q <= ZERO;
      instret_q    <= '0;
    end else begin
      valid_q      <= capture;
      rf_we_q      <= capture & we_next;
      misaligned_q <= capture & is_load_i & load_misaligned;
      if (capture) begin
        rf_rd_q    <= rd_i;
        rf_wdata_q <= is_load_i ? load_data : wb_value_i;
        instret_q  <= instret_q + 1'b1;
      end
    end
  end

  assign rf_we_o      = rf_we_q;
  assign rf_rd_o      = rf_rd_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign fwd_valid_o  = rf_we_q;
  assign fwd_rd_o     = rf_rd_q;
  assign fwd_data_o   = rf_wdata_q;
  assign misaligned_o = misaligned_q;
  assign instret_o    = instret_q;

  // The internal valid bit is kept for pipeline bookkeeping; no port exposes it.
  logic unused_valid;
  assign unused_valid = valid_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases plus randomized traffic against
// an arithmetic reference model; a 3-bit-counter instance exercises instret wrap-around.
module tb_mem_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [4:0]  rd_i;
  logic        wb_en_i;
  logic [31:0] wb_value_i;
  logic        is_load_i;
  logic [2:0]  load_funct3_i;
  logic [1:0]  addr_lo_i;
  logic        stall_i;
  logic        flush_i;

  logic        rf_we_o, fwd_valid_o, misaligned_o;
  logic [4:0]  rf_rd_o, fwd_rd_o;
  logic [31:0] rf_wdata_o, fwd_data_o;
  logic [63:0] instret_o;

  logic        w_we, w_fv, w_mis;
  logic [4:0]  w_rd, w_frd;
  logic [31:0] w_wd, w_fd;
  logic [2:0]  w_instret;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic        exp_we, exp_mis, exp_data_known;
  logic [4:0]  exp_rd;
  logic [31:0] exp_wdata;
  logic [63:0] exp_instret;

  always #5 clk_i = ~clk_i;

  mem_wb_stage #(.XLEN(32), .INSTRET_W(64)) dut (
    .clk_i(clk_i), .rst(rst), .valid_i(valid_i), .rd_i(rd_i), .wb_en_i(wb_en_i),
    .wb_value_i(wb_value_i), .is_load_i(is_load_i), .load_funct3_i(load_funct3_i),
    .addr_lo_i(addr_lo_i), .stall_i(stall_i), .flush_i(flush_i),
    .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_wdata_o(rf_wdata_o),
    .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o),
    .misaligned_o(misaligned_o), .instret_o(instret_o)
  );

  mem_wb_stage #(.XLEN(32), .INSTRET_W(3)) dut_wrap (
    .clk_i(clk_i), .rst(rst), .valid_i(valid_i), .rd_i(rd_i), .wb_en_i(wb_en_i),
    .wb_value_i(wb_value_i), .is_load_i(is_load_i), .load_funct3_i(load_funct3_i),
    .addr_lo_i(addr_lo_i), .stall_i(stall_i), .flush_i(flush_i),
    .rf_we_o(w_we), .rf_rd_o(w_rd), .rf_wdata_o(w_wd),
    .fwd_valid_o(w_fv), .fwd_rd_o(w_frd), .fwd_data_o(w_fd),
    .misaligned_o(w_mis), .instret_o(w_instret)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Load result from first principles: shift/mask the addressed field, then extend.
  task automatic ref_load(input logic [31:0] word, input logic [2:0] f3, input int a,
                          output logic [31:0] data, output logic ok, output logic mis);
    longint unsigned field;
    data = 32'd0; ok = 1'b1; mis = 1'b0;
    case (f3)
      3'd0, 3'd4: begin
        field = (longint'(word) >> (8 * a)) & 64'hFF;
        data  = (f3 == 3'd0 && field >= 128) ? 32'(field + 64'hFFFF_FF00) : 32'(field);
      end
      3'd1, 3'd5: begin
        mis   = (a % 2) != 0;
        ok    = !mis;
        field = (longint'(word) >> (16 * (a / 2))) & 64'hFFFF;
        data  = (f3 == 3'd1 && field >= 32768) ? 32'(field + 64'hFFFF_0000) : 32'(field);
      end
      3'd2: begin
        mis  = (a != 0);
        ok   = !mis;
        data = word;
      end
      default: begin
        ok = 1'b0;
      end
    endcase
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic en,
                       input logic [31:0] val, input logic ld, input logic [2:0] f3,
                       input logic [1:0] a, input logic st, input logic fl);
    valid_i = v; rd_i = rd; wb_en_i = en; wb_value_i = val; is_load_i = ld;
    load_funct3_i = f3; addr_lo_i = a; stall_i = st; flush_i = fl;
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic cycle();
    logic [31:0] ld_data;
    logic        ld_ok, ld_mis;
    @(posedge clk_i);
    if (rst) begin
      exp_we = 0; exp_mis = 0; exp_rd = 0; exp_wdata = 0; exp_instret = 0;
      exp_data_known = 1;
    end else if (flush_i || stall_i || !valid_i) begin
      exp_we = 0; exp_mis = 0;
    end else begin
      ref_load(wb_value_i, load_funct3_i, int'(addr_lo_i), ld_data, ld_ok, ld_mis);
      exp_rd         = rd_i;
      exp_wdata      = is_load_i ? ld_data : wb_value_i;
      exp_mis        = is_load_i && ld_mis;
      exp_we         = wb_en_i && (rd_i != 0) && (!is_load_i || ld_ok);
      exp_instret    = exp_instret + 1;
      exp_data_known = exp_we;
    end
    @(negedge clk_i);
    check("rf_we", 64'(rf_we_o), 64'(exp_we));
    check("fwd_valid", 64'(fwd_valid_o), 64'(exp_we));
    check("misaligned", 64'(misaligned_o), 64'(exp_mis));
    check("instret", instret_o, exp_instret);
    check("instret_wrap3", 64'(w_instret), exp_instret % 8);
    if (exp_data_known) begin
      check("rf_rd", 64'(rf_rd_o), 64'(exp_rd));
      check("rf_wdata", 64'(rf_wdata_o), 64'(exp_wdata));
      check("fwd_rd", 64'(fwd_rd_o), 64'(exp_rd));
      check("fwd_data", 64'(fwd_data_o), 64'(exp_wdata));
    end
  endtask

  localparam logic [31:0] LW_WORD = 32'h80F0_7F81;

  initial begin
    exp_we = 0; exp_mis = 0; exp_rd = 0; exp_wdata = 0; exp_instret = 0; exp_data_known = 0;
    rst = 1;
    drive(1, 5'd5, 1, 32'h1234_5678, 0, 3'd0, 2'd0, 0, 0);
    @(negedge clk_i);
    cycle(); cycle();
    check("reset_we_const", 64'(rf_we_o), 64'd0);
    check("reset_instret_const", instret_o, 64'd0);
    rst = 0;
    cycle();
    check("first_capture_instret", instret_o, 64'd1);
    check("first_capture_rd", 64'(rf_rd_o), 64'd5);

    // ALU writeback, then rd=0
    drive(1, 5'd3, 1, 32'hDEAD_BEEF, 0, 3'd0, 2'd0, 0, 0); cycle();
    check("alu_wdata", 64'(rf_wdata_o), 64'hDEAD_BEEF);
    drive(1, 5'd0, 1, 32'hCAFE_F00D, 0, 3'd0, 2'd0, 0, 0); cycle();
    check("rd0_we", 64'(rf_we_o), 64'd0);

    // Load extension table
    drive(1, 5'd7, 1, LW_WORD, 1, 3'b000, 2'd0, 0, 0); cycle();
    check("lb0", 64'(rf_wdata_o), 64'hFFFF_FF81);
    drive(1, 5'd7, 1, LW_WORD, 1, 3'b100, 2'd3, 0, 0); cycle();
    check("lbu3", 64'(rf_wdata_o), 64'h0000_0080);
    drive(1, 5'd7, 1, LW_WORD, 1, 3'b001, 2'd2, 0, 0); cycle();
    check("lh2", 64'(rf_wdata_o), 64'hFFFF_80F0);
    drive(1, 5'd7, 1, LW_WORD, 1, 3'b101, 2'd0, 0, 0); cycle();
    check("lhu0", 64'(rf_wdata_o), 64'h0000_7F81);
    drive(1, 5'd7, 1, LW_WORD, 1, 3'b010, 2'd0, 0, 0); cycle();
    check("lw0", 64'(rf_wdata_o), 64'h80F0_7F81);

    // Misaligned LW: one-cycle pulse, no write, still retired
    drive(1, 5'd9, 1, LW_WORD, 1, 3'b010, 2'd1, 0, 0); cycle();
    check("lw_mis_pulse", 64'(misaligned_o), 64'd1);
    drive(0, 5'd9, 1, LW_WORD, 1, 3'b010, 2'd1, 0, 0); cycle();
    check("lw_mis_drop", 64'(misaligned_o), 64'd0);

    // Stall 3 cycles, then the load goes through; then flush+stall together
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd11, 1, LW_WORD, 1, 3'b010, 2'd0, 1, 0); cycle();
    end
    drive(1, 5'd11, 1, LW_WORD, 1, 3'b010, 2'd0, 0, 0); cycle();
    drive(1, 5'd12, 1, 32'h5555_AAAA, 0, 3'd0, 2'd0, 1, 1); cycle();
    drive(1, 5'd13, 1, 32'h0F0F_0F0F, 1, 3'b011, 2'd0, 0, 0); cycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [2:0] f3;
      case ($urandom_range(0, 5))
        0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
        3: f3 = 3'b100; 4: f3 = 3'b101;
        default: f3 = 3'($urandom_range(0, 7));
      endcase
      rst = ($urandom_range(0, 99) < 2);
      drive($urandom_range(0, 9) < 8,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom_range(0, 9) < 8, $urandom(), 1'($urandom_range(0, 1)), f3,
            2'($urandom_range(0, 3)), $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 10);
      cycle();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
